// File: rtl/usart_tx_arbiter.sv
// usart_tx_arbiter: message-granular round-robin sharing of one USART
// transmitter among NUM_REQ byte-stream requesters.
// Optional build macro USART_ARB_TIMEOUT_EN: releases a granted requester
// that leaves GRANT idle for TIMEOUT_CYCLES cycles.
module usart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 comm_clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic                 arb_busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_err
        $error("usart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_LAUNCH,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      last_q, last_d;
    logic [7:0]         txd_q, txd_d;
    logic               lflag_q, lflag_d;

    logic [7:0]         data_arr [NUM_REQ];
    logic               g_valid;
    logic [7:0]         g_data;
    logic               g_last;
    logic               pick_found;
    logic [IW-1:0]      pick_idx;
    logic [IW-1:0]      cand;
    logic               tmo;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign data_arr[i] = req_data[8*i +: 8];
    end

    // Only the current owner's lane is ever looked at.
    assign g_valid = req_valid[gidx_q];
    assign g_data  = data_arr[gidx_q];
    assign g_last  = req_last[gidx_q];

    // Round-robin pick: first valid requester after the last served one.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IW'((int'(last_q) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

`ifdef USART_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tcnt_q, tcnt_d;

    // Idle-in-GRANT counter; any transfer or leaving GRANT clears it.
    always_comb begin
        tcnt_d = '0;
        if (state_q == S_GRANT && !g_valid) begin
            tcnt_d = tcnt_q + TW'(1);
        end
    end

    // Timeout counter register.
    always_ff @(posedge comm_clock) begin
        if (reset) begin
            tcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
        end
    end

    // This cycle is the TIMEOUT_CYCLES-th idle one; a transfer overrides it.
    assign tmo = (state_q == S_GRANT) && !g_valid &&
                 (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif

    // Next-state logic: arbitration, byte capture, launch and drain.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        txd_d   = txd_q;
        lflag_d = lflag_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    gidx_d  = pick_idx;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (g_valid) begin
                    txd_d   = g_data;
                    lflag_d = g_last;
                    state_d = S_LAUNCH;
                end else if (tmo) begin
                    last_d  = gidx_q;
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: state_d = S_HOLD;
            // tx_busy may not be visible yet; skip one cycle before watching it.
            S_HOLD:   state_d = S_DRAIN;
            S_DRAIN: begin
                if (!tx_busy) begin
                    if (lflag_q) begin
                        last_d  = gidx_q;
                        grant_d = '0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_GRANT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset drops any latched byte, leaves the wire alone.
    always_ff @(posedge comm_clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            txd_q   <= 8'h00;
            lflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            txd_q   <= txd_d;
            lflag_q <= lflag_d;
        end
    end

    assign req_ready = (state_q == S_GRANT) ? grant_q : '0;
    assign grant     = grant_q;
    assign tx_data   = txd_q;
    assign tx_start  = (state_q == S_LAUNCH);
    assign arb_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_usart_tx_arbiter.sv
// Directed bench for usart_tx_arbiter with a queue-fed requester model and
// a transmitter model whose frame length is set per scenario.
module tb_usart_tx_arbiter;

    localparam int N = 4;

    logic           comm_clock = 1'b0;
    logic           reset      = 1'b1;
    logic [N-1:0]   req_valid  = '0;
    logic [8*N-1:0] req_data   = '0;
    logic [N-1:0]   req_last   = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy    = 1'b0;
    logic           arb_busy;

    usart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
        .comm_clock (comm_clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .grant      (grant),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .arb_busy   (arb_busy)
    );

    always #5 comm_clock = ~comm_clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge comm_clock) cyc++;

    // Requester model: per-requester FIFO of {last, byte}.
    logic [8:0] rbuf [N][32];
    int         rhead [N] = '{default: 0};
    int         rtail [N] = '{default: 0};
    int         vrise [N] = '{default: 0};
    logic [N-1:0] fire;

    task automatic push(input int r, input logic [7:0] d, input logic l);
        rbuf[r][rtail[r] % 32] = {l, d};
        rtail[r]++;
    endtask

    always begin
        @(negedge comm_clock);
        fire = req_valid & req_ready & {N{~reset}};
        @(posedge comm_clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (fire[i]) rhead[i]++;
            if (rhead[i] != rtail[i]) begin
                if (!req_valid[i]) vrise[i] = cyc;
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = rbuf[i][rhead[i] % 32][7:0];
                req_last[i]        = rbuf[i][rhead[i] % 32][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    end

    // Transmitter model: busy for frame_len cycles starting the cycle after tx_start.
    int   frame_len = 8;
    int   bcnt = 0;
    logic st_s = 1'b0;

    always @(posedge comm_clock) begin
        if (st_s) begin
            tx_busy <= 1'b1;
            bcnt    <= frame_len - 1;
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
        end else begin
            tx_busy <= 1'b0;
        end
    end

    // Monitor: log launched bytes, watch handshake and ownership invariants.
    logic [7:0] txlog [64];
    int         scyc  [64];
    int         nlog = 0;
    logic [7:0] launched = 8'h00;
    logic       low_since = 1'b1;
    logic       mon_en = 1'b1;
    logic       exp_g_en = 1'b0;
    logic [N-1:0] exp_g = '0;
    int last_start = 0, last_f = 0;
    int hs_err = 0, gap_err = 0, stab_err = 0, onehot_err = 0, rdy_err = 0, gown_err = 0;

    always @(negedge comm_clock) begin
        st_s = tx_start;
        if ($countones(grant) > 1) onehot_err++;
        if ((req_ready & ~grant) != '0) rdy_err++;
        if (exp_g_en && grant != '0 && grant != exp_g) gown_err++;
        if (tx_start) begin
            if (mon_en && nlog > 0 && !low_since) hs_err++;
            if (mon_en && nlog > 0 && (cyc - last_start) < 3 + last_f) gap_err++;
            low_since = 1'b0;
            last_start = cyc;
            last_f = frame_len;
            txlog[nlog % 64] = tx_data;
            scyc[nlog % 64] = cyc;
            nlog++;
            launched = tx_data;
        end else begin
            if (!tx_busy) low_since = 1'b1;
            if (mon_en && tx_busy && tx_data !== launched) stab_err++;
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin @(posedge comm_clock); #1; end
    endtask

    task automatic wait_starts(input int n, input int budget, input string tag);
        int k = 0;
        while (nlog < n && k < budget) begin @(posedge comm_clock); #1; k++; end
        chk(tag, 32'(nlog >= n), 1);
    endtask

    function automatic logic drained();
        logic d = !arb_busy && !tx_busy && (req_valid == '0);
        for (int i = 0; i < N; i++) if (rhead[i] != rtail[i]) d = 1'b0;
        return d;
    endfunction

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        while (!drained() && k < budget) begin @(posedge comm_clock); #1; k++; end
        chk(tag, 32'(drained()), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
    endtask

    task automatic chk_reset_outs(input string pfx);
        chk({pfx, "_ready"}, req_ready, 0);
        chk({pfx, "_grant"}, grant, 0);
        chk({pfx, "_txdata"}, tx_data, 8'h00);
        chk({pfx, "_start"}, tx_start, 0);
        chk({pfx, "_arbbusy"}, arb_busy, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, t0, t1, k;
        cycles(2);
        chk_reset_outs("rst");
        reset = 1'b0;

        // Single requester, two-byte message, long frames.
        frame_len = 320;
        exp_g = 4'b0001; exp_g_en = 1'b1;
        base = nlog;
        push(0, 8'hA5, 1'b0);
        push(0, 8'h3C, 1'b1);
        wait_starts(base + 1, 50, "t1_first_start");
        chk("t1_latency", scyc[base % 64] - vrise[0], 2);
        wait_idle(1500, "t1_idle");
        chk("t1_nstarts", nlog - base, 2);
        chk("t1_byte0", txlog[base % 64], 8'hA5);
        chk("t1_byte1", txlog[(base + 1) % 64], 8'h3C);
        chk("t1_grant_owner", gown_err, 0);
        chk("t1_grant_end", grant, 0);
        exp_g_en = 1'b0;

        // Message atomicity: req 2 arrives during req 1's second byte.
        frame_len = 8;
        base = nlog;
        push(1, 8'h10, 1'b0);
        push(1, 8'h11, 1'b0);
        push(1, 8'h12, 1'b1);
        wait_starts(base + 2, 200, "t2_second_start");
        push(2, 8'h20, 1'b1);
        wait_idle(500, "t2_idle");
        chk("t2_nstarts", nlog - base, 4);
        chk("t2_b0", txlog[base % 64], 8'h10);
        chk("t2_b1", txlog[(base + 1) % 64], 8'h11);
        chk("t2_b2", txlog[(base + 2) % 64], 8'h12);
        chk("t2_b3", txlog[(base + 3) % 64], 8'h20);
        chk("t2_ready_in_grant", rdy_err, 0);

        // Round-robin with all four requesters continuously active.
        do_reset();
        frame_len = 3;
        base = nlog;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push(i, 8'(i), 1'b1);
        wait_idle(500, "t3_idle");
        chk("t3_nstarts", nlog - base, 8);
        for (int j = 0; j < 8; j++) chk("t3_rr_order", txlog[(base + j) % 64], j % 4);

        // After reset only req 3 and req 0: req 0 first.
        do_reset();
        base = nlog;
        push(3, 8'h33, 1'b1);
        push(0, 8'h0A, 1'b1);
        wait_idle(300, "t3b_idle");
        chk("t3b_first", txlog[base % 64], 8'h0A);
        chk("t3b_second", txlog[(base + 1) % 64], 8'h33);

        // Move the pointer to requester 0 so a missing pointer reset shows up.
        base = nlog;
        push(0, 8'h55, 1'b1);
        wait_idle(200, "t4_pre_idle");
        chk("t4_pre_byte", txlog[base % 64], 8'h55);

        // Reset during DRAIN of byte 2 of 4.
        mon_en = 1'b0;
        frame_len = 20;
        base = nlog;
        push(1, 8'h40, 1'b0);
        push(1, 8'h41, 1'b0);
        push(1, 8'h42, 1'b0);
        push(1, 8'h43, 1'b1);
        wait_starts(base + 2, 200, "t4_second_start");
        cycles(1);
        chk("t4_in_drain", {arb_busy, tx_busy, tx_start}, 3'b110);
        push(0, 8'h50, 1'b1);
        reset = 1'b1;
        cycles(1);
        chk_reset_outs("t4_rst");
        reset = 1'b0;
        wait_idle(800, "t4_idle");
        chk("t4_nstarts", nlog - base, 5);
        chk("t4_b2_req0", txlog[(base + 2) % 64], 8'h50);
        chk("t4_b3", txlog[(base + 3) % 64], 8'h42);
        chk("t4_b4", txlog[(base + 4) % 64], 8'h43);
        cycles(2);
        mon_en = 1'b1;

        // Granted requester goes quiet after one non-last byte; req 3 waits.
        frame_len = 4;
        base = nlog;
        push(2, 8'h77, 1'b0);
        push(3, 8'h33, 1'b1);
        wait_starts(base + 1, 50, "t5_first_start");
        chk("t5_byte", txlog[base % 64], 8'h77);
        k = 0;
        while (!req_ready[2] && k < 50) begin cycles(1); k++; end
        chk("t5_regrant", req_ready, 4'b0100);
        t0 = cyc;
`ifdef USART_ARB_TIMEOUT_EN
        k = 0;
        while (grant[2] && k < 100) begin cycles(1); k++; end
        t1 = cyc;
        chk("t5_timeout_cycles", t1 - t0, 16);
        wait_idle(200, "t5_idle");
        chk("t5_nstarts", nlog - base, 2);
        chk("t5_req3_byte", txlog[(base + 1) % 64], 8'h33);
`else
        t1 = t0;
        cycles(1000);
        chk("t5_grant_held", grant, 4'b0100);
        chk("t5_no_extra_start", nlog - base, 1);
        chk("t5_hold_time", cyc - t1, 1000);
        do_reset();
        wait_idle(200, "t5_idle");
        chk("t5_nstarts", nlog - base, 2);
        chk("t5_req3_byte", txlog[(base + 1) % 64], 8'h33);
`endif

        // Invariants observed across the whole run.
        chk("inv_busy_low_before_start", hs_err, 0);
        chk("inv_start_spacing", gap_err, 0);
        chk("inv_txdata_stable", stab_err, 0);
        chk("inv_grant_onehot", onehot_err, 0);
        chk("inv_ready_in_grant", rdy_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usart_tx_arbiter.md
Name: usart_tx_arbiter

Overview:
- Shares one USART transmitter among NUM_REQ byte-stream requesters, such as a command echo path, a debug monitor and a status reporter.
- Arbitration is round-robin at message granularity. Once a requester is granted, it holds the transmitter until its byte marked req_last has fully shifted out.
- Sits between the requesters and the transmitter's start/busy interface, all in the comm_clock domain.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- TIMEOUT_CYCLES, 1024, idle cycles allowed for a granted requester before forced release; used only with USART_ARB_TIMEOUT_EN; must be ≥ 2.

Ports:
- comm_clock  input  1  sole clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester byte available.
- req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  input  NUM_REQ  byte is the final byte of the message; qualified by req_valid.
- req_ready  output  NUM_REQ  byte accepted when valid and ready are both high in the same cycle.
- grant  output  NUM_REQ  one-hot owner of the transmitter; all zero when nobody owns it.
- tx_data  output  8  byte to the transmitter; stable from tx_start until tx_busy falls.
- tx_start  output  1  one-cycle pulse that launches a frame.
- tx_busy  input  1  transmitter is shifting; it must rise no later than the cycle after tx_start.
- arb_busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset values: req_ready=0, grant=0, tx_data=8'h00, tx_start=0, arb_busy=0, state=IDLE.
  - The round-robin pointer resets to last=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation: the arbiter returns to IDLE next edge. A frame already in the transmitter is not aborted. The latched byte is dropped.
- States are IDLE, GRANT, LAUNCH, HOLD and DRAIN.
- IDLE:
  - If any req_valid is high, choose the first set bit scanning from (last+1) mod NUM_REQ upward, with wrap-around.
  - Register the choice in grant and go to GRANT.
  - If no req_valid is high, stay in IDLE.
- GRANT:
  - req_ready[g] = 1, where g is the granted requester; all other req_ready bits are 0. req_ready is a decode of registered state only.
  - On req_valid[g]: latch req_data[g] into tx_data and req_last[g] into last_flag, then go to LAUNCH.
  - Valid from non-granted requesters is ignored; they wait.
- LAUNCH: tx_start=1 for exactly this cycle, then go to HOLD.
- HOLD: one cycle that masks tx_busy while the transmitter registers it, then go to DRAIN.
- DRAIN: wait while tx_busy=1. When tx_busy=0:
  - if last_flag=1: set last=g, clear grant, go to IDLE;
  - otherwise go back to GRANT with the same g.
- Timing:
  - Byte-accept to tx_start latency is 1 cycle.
  - From IDLE, request to first tx_start is 2 cycles.
  - tx_start pulses are at least 3 + frame-length cycles apart.
- Simultaneous requests: at most one grant is ever set, and grant is stable for the whole message.
- Grant release and re-arbitration never share a cycle. IDLE always lasts at least 1 cycle between messages.
- tx_busy stuck high holds the arbiter in DRAIN indefinitely. This is the transmitter's contract; the timeout does not cover DRAIN.
- A single-byte message is a byte with req_last=1 on the first transfer.

Optional Feature:
- Macro: USART_ARB_TIMEOUT_EN.
- Defined:
  - A counter counts cycles spent in GRANT with req_valid[g]=0. It clears on every transfer and on leaving GRANT.
  - When the count reaches TIMEOUT_CYCLES, the arbiter treats the message as ended: last=g, grant cleared, back to IDLE. No byte is sent.
  - A transfer in the same cycle as the timeout wins; the byte is accepted and the timeout is ignored.
- Not defined: no counter exists, and a granted requester may hold the transmitter indefinitely between bytes.

Test Plan:
- Single requester, one message:
  - Stimulus: req 0 sends bytes 8'hA5, 8'h3C (last on 8'h3C); bench transmitter model holds tx_busy for 320 cycles.
  - Required: tx_data 8'hA5 then 8'h3C; exactly 2 tx_start pulses; first tx_start 2 cycles after req_valid; grant=4'b0001 throughout, then 0.
- Message atomicity:
  - Stimulus: req 1 sends 3 bytes (8'h10, 8'h11, 8'h12 last); req 2 asserts valid with 8'h20 during req 1's second byte.
  - Required: transmit order 10, 11, 12, 20; req_ready[2] stays 0 until grant moves to 4'b0100.
- Round-robin fairness:
  - Stimulus: all 4 requesters continuously send single-byte messages with data = index.
  - Required: transmitted sequence is 00, 01, 02, 03, 00, ...
  - Stimulus: after reset with only req 3 and req 0 active.
  - Required: req 0 is served first, then req 3.
- Reset mid-message:
  - Stimulus: reset asserted 1 cycle while in DRAIN of byte 2 of 4.
  - Required: next edge has all outputs at reset values; the next arbitration starts with requester 0 priority; no tx_start during reset.
- Timeout (USART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16):
  - Stimulus: req 2 sends 1 non-last byte, then drops valid.
  - Required: grant clears 16 cycles after entering GRANT; a pending req 3 is then granted; no extra tx_start.
  - Without the macro: grant to req 2 persists for at least 1000 cycles.
- tx_busy handshake:
  - Stimulus: transmitter model raises tx_busy 1 cycle after tx_start.
  - Required: no second tx_start until tx_busy has been low at least 1 cycle; tx_data is unchanged while tx_busy=1.
